// File: rtl/reg_1to2_demux.sv
// -----------------------------------------------------------------------------
// reg_1to2_demux
//   Registered 1-to-2 stream demultiplexer. One signed word per input handshake
//   is steered by sel_in into one of two private 2-entry FIFOs. Each FIFO feeds
//   its own output channel, so a stalled consumer cannot disturb the other one.
//
// Optional feature macro: DEMUX_XFER_CNT_EN
//   Defined   : per-channel output-handshake counters (wrap at 2^COUNT_W).
//   Undefined : counters are not built; count ports are tied to 0.
//
// Ports
//   clk_in           in   system clock, rising edge
//   rst_in           in   synchronous active-high reset
//   d_in             in   signed input word (DATA_W)
//   sel_in           in   destination channel (0/1), sampled with d_in
//   valid_in         in   d_in/sel_in valid
//   ready_output     out  selected channel can accept (combinational)
//   y0_output        out  channel 0 head word
//   y0_valid_output  out  channel 0 head valid
//   y0_ready_in      in   channel 0 consumer ready
//   y1_output        out  channel 1 head word
//   y1_valid_output  out  channel 1 head valid
//   y1_ready_in      in   channel 1 consumer ready
//   xfer0_cnt_output out  channel 0 completed transfers (COUNT_W)
//   xfer1_cnt_output out  channel 1 completed transfers (COUNT_W)
// -----------------------------------------------------------------------------
module reg_1to2_demux #(
  parameter int DATA_W  = 8,
  parameter int COUNT_W = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic signed [DATA_W-1:0]  d_in,
  input  logic                      sel_in,
  input  logic                      valid_in,
  output logic                      ready_output,
  output logic signed [DATA_W-1:0]  y0_output,
  output logic                      y0_valid_output,
  input  logic                      y0_ready_in,
  output logic signed [DATA_W-1:0]  y1_output,
  output logic                      y1_valid_output,
  input  logic                      y1_ready_in,
  output logic [COUNT_W-1:0]        xfer0_cnt_output,
  output logic [COUNT_W-1:0]        xfer1_cnt_output
);

  logic [1:0] w_full;
  logic [1:0] w_y_ready;

  assign w_y_ready = {y1_ready_in, y0_ready_in};

  // Readiness only looks at the selected channel's occupancy; a full channel
  // refuses input even if its consumer pops on the same edge.
  assign ready_output = sel_in ? ~w_full[1] : ~w_full[0];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      localparam logic CH_SEL = 1'(gi);

      // Shift-style FIFO: r_head is the visible word, r_tail the second entry.
      // Keeping the head as its own register lets it hold its last value when
      // the channel drains empty.
      logic signed [DATA_W-1:0] r_head;
      logic signed [DATA_W-1:0] r_tail;
      logic [1:0]               r_occ;
      logic                     w_push;
      logic                     w_pop;
      logic [COUNT_W-1:0]       w_cnt;

      assign w_full[gi] = (r_occ == 2'd2);
      assign w_push     = valid_in && ready_output && (sel_in == CH_SEL);
      assign w_pop      = (r_occ != 2'd0) && w_y_ready[gi];

      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          r_head <= '0;
          r_tail <= '0;
          r_occ  <= 2'd0;
        end else begin
          case ({w_push, w_pop})
            2'b10: begin
              if (r_occ == 2'd0) r_head <= d_in;
              else               r_tail <= d_in;
              r_occ <= r_occ + 2'd1;
            end
            2'b01: begin
              if (r_occ == 2'd2) r_head <= r_tail;
              r_occ <= r_occ - 2'd1;
            end
            2'b11: begin
              // Push can only coincide with pop at occupancy 1 (full blocks
              // push), so the new word becomes the head directly.
              if (r_occ == 2'd2) begin
                r_head <= r_tail;
                r_tail <= d_in;
              end else begin
                r_head <= d_in;
              end
            end
            default: ;
          endcase
        end
      end

`ifdef DEMUX_XFER_CNT_EN
      logic [COUNT_W-1:0] r_cnt;

      always_ff @(posedge clk_in) begin
        if (rst_in)     r_cnt <= '0;
        else if (w_pop) r_cnt <= r_cnt + 1'b1;
      end

      assign w_cnt = r_cnt;
`else
      assign w_cnt = '0;
`endif
    end
  endgenerate

  assign y0_output        = g_ch[0].r_head;
  assign y0_valid_output  = (g_ch[0].r_occ != 2'd0);
  assign y1_output        = g_ch[1].r_head;
  assign y1_valid_output  = (g_ch[1].r_occ != 2'd0);
  assign xfer0_cnt_output = g_ch[0].w_cnt;
  assign xfer1_cnt_output = g_ch[1].w_cnt;

endmodule

// File: tb/tb_reg_1to2_demux.sv
// -----------------------------------------------------------------------------
// tb_reg_1to2_demux
//   Directed self-checking bench for reg_1to2_demux (DATA_W=8, COUNT_W=2).
//   Counter expectations follow DEMUX_XFER_CNT_EN: wrapped counts when
//   defined, constant 0 otherwise.
// -----------------------------------------------------------------------------
module tb_reg_1to2_demux;

  localparam int DATA_W  = 8;
  localparam int COUNT_W = 2;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic [DATA_W-1:0]  d_in;
  logic               sel_in;
  logic               valid_in;
  logic               ready_output;
  logic [DATA_W-1:0]  y0_output;
  logic               y0_valid_output;
  logic               y0_ready_in;
  logic [DATA_W-1:0]  y1_output;
  logic               y1_valid_output;
  logic               y1_ready_in;
  logic [COUNT_W-1:0] xfer0_cnt_output;
  logic [COUNT_W-1:0] xfer1_cnt_output;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_in = ~clk_in;

  reg_1to2_demux #(.DATA_W(DATA_W), .COUNT_W(COUNT_W)) u_dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .d_in             (d_in),
    .sel_in           (sel_in),
    .valid_in         (valid_in),
    .ready_output     (ready_output),
    .y0_output        (y0_output),
    .y0_valid_output  (y0_valid_output),
    .y0_ready_in      (y0_ready_in),
    .y1_output        (y1_output),
    .y1_valid_output  (y1_valid_output),
    .y1_ready_in      (y1_ready_in),
    .xfer0_cnt_output (xfer0_cnt_output),
    .xfer1_cnt_output (xfer1_cnt_output)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
      $display("ok   %-14s obs=%0h exp=%0h", tag, obs, exp);
    end else begin
      $display("FAIL %-14s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Expected counter value after n pops on a channel.
  function automatic logic [31:0] cnt_exp(input int n);
    logic [31:0] v;
`ifdef DEMUX_XFER_CNT_EN
    v = 32'(n % 4);
`else
    v = 32'd0;
    if (n < 0) v = 32'd1;
`endif
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_in = 1'b1; d_in = '0; sel_in = 1'b0; valid_in = 1'b0;
    y0_ready_in = 1'b0; y1_ready_in = 1'b0;
    tick(); tick();
    rst_in = 1'b0;
    check("rst_y0v", 32'(y0_valid_output), 32'd0);
    check("rst_y1v", 32'(y1_valid_output), 32'd0);
    check("rst_y0", 32'(y0_output), 32'd0);
    check("rst_y1", 32'(y1_output), 32'd0);
    check("rst_ready", 32'(ready_output), 32'd1);
    check("rst_cnt0", 32'(xfer0_cnt_output), cnt_exp(0));

    // Single word to channel 0, consumer ready: appears after one edge, pops next.
    y0_ready_in = 1'b1; d_in = 8'd30; sel_in = 1'b0; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    check("t1_y0", 32'(y0_output), 32'd30);
    check("t1_y0v", 32'(y0_valid_output), 32'd1);
    check("t1_y1v", 32'(y1_valid_output), 32'd0);
    tick();
    check("t1_y0v_pop", 32'(y0_valid_output), 32'd0);
    check("t1_y0_hold", 32'(y0_output), 32'd30);
    check("t1_cnt0", 32'(xfer0_cnt_output), cnt_exp(1));
    y0_ready_in = 1'b0;

    // Channel 1: 45 then -128, consumer stalled then released.
    d_in = 8'd45; sel_in = 1'b1; valid_in = 1'b1;
    tick();
    check("t2_y1", 32'(y1_output), 32'd45);
    check("t2_y1v", 32'(y1_valid_output), 32'd1);
    check("t2_y0v", 32'(y0_valid_output), 32'd0);
    d_in = 8'h80;
    tick();
    valid_in = 1'b0;
    check("t2_y1_head", 32'(y1_output), 32'd45);
    y1_ready_in = 1'b1;
    tick();
    check("t2_neg", 32'(y1_output), 32'h80);
    check("t2_neg_v", 32'(y1_valid_output), 32'd1);
    tick();
    check("t2_drain_v", 32'(y1_valid_output), 32'd0);
    check("t2_drain_y", 32'(y1_output), 32'h80);
    check("t2_cnt1", 32'(xfer1_cnt_output), cnt_exp(2));
    check("t2_cnt0", 32'(xfer0_cnt_output), cnt_exp(1));
    y1_ready_in = 1'b0;

    // Fill channel 0 with 10, 20 while stalled; check per-channel readiness.
    sel_in = 1'b0; valid_in = 1'b1;
    d_in = 8'd10; tick();
    d_in = 8'd20; tick();
    #1;
    check("t3_rdy_sel0", 32'(ready_output), 32'd0);
    sel_in = 1'b1; #1;
    check("t3_rdy_sel1", 32'(ready_output), 32'd1);
    valid_in = 1'b0; sel_in = 1'b0;
    y0_ready_in = 1'b1; #1;
    check("t3_rdy_fullpop", 32'(ready_output), 32'd0);
    check("t3_head10", 32'(y0_output), 32'd10);
    tick();
    check("t3_head20", 32'(y0_output), 32'd20);
    check("t3_cnt0_a", 32'(xfer0_cnt_output), cnt_exp(2));
    tick();
    check("t3_empty", 32'(y0_valid_output), 32'd0);
    check("t3_cnt0_b", 32'(xfer0_cnt_output), cnt_exp(3));
    y0_ready_in = 1'b0;

    // One entry (5), then push 7 with simultaneous pop: occupancy stays 1.
    d_in = 8'd5; valid_in = 1'b1; tick();
    d_in = 8'd7; y0_ready_in = 1'b1; tick();
    valid_in = 1'b0;
    check("t4_head7", 32'(y0_output), 32'd7);
    check("t4_v", 32'(y0_valid_output), 32'd1);
    check("t4_cnt0_a", 32'(xfer0_cnt_output), cnt_exp(4));
    tick();
    check("t4_occ1", 32'(y0_valid_output), 32'd0);
    check("t4_cnt0_b", 32'(xfer0_cnt_output), cnt_exp(5));
    y0_ready_in = 1'b0;

    // Two entries in channel 1 plus one in channel 0, then reset.
    sel_in = 1'b1; valid_in = 1'b1;
    d_in = 8'd1; tick();
    d_in = 8'd2; tick();
    sel_in = 1'b0; d_in = 8'd3; tick();
    valid_in = 1'b0;
    check("t5_pre_y1", 32'(y1_output), 32'd1);
    rst_in = 1'b1; y1_ready_in = 1'b1;
    tick();
    rst_in = 1'b0; y1_ready_in = 1'b0;
    check("t5_y0v", 32'(y0_valid_output), 32'd0);
    check("t5_y1v", 32'(y1_valid_output), 32'd0);
    check("t5_y0", 32'(y0_output), 32'd0);
    check("t5_y1", 32'(y1_output), 32'd0);
    check("t5_cnt0", 32'(xfer0_cnt_output), 32'd0);
    check("t5_cnt1", 32'(xfer1_cnt_output), 32'd0);
    sel_in = 1'b0; #1;
    check("t5_rdy0", 32'(ready_output), 32'd1);
    sel_in = 1'b1; #1;
    check("t5_rdy1", 32'(ready_output), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_1to2_demux.md
Name: reg_1to2_demux

Overview:
- Registered 1-to-2 stream demultiplexer: the opposite direction of the datapath's 2-to-1 selector.
- Accepts one signed word per handshake on a single input channel and steers it by sel_in to one of two output channels.
- Each output channel has a private 2-entry buffer, so one stalled consumer never corrupts the other.
- Used to split a CORDIC operand/result stream between two consumers (e.g. rotation vs. vectoring stage).

Parameters:
- DATA_W, 8, width of signed data words
- COUNT_W, 16, width of per-channel transfer counters (feature-dependent)

Ports:
- clk_in  input  1  system clock, rising edge
- rst_in  input  1  synchronous, active-high reset
- d_in  input  DATA_W  signed input word
- sel_in  input  1  destination: 0 -> channel 0, 1 -> channel 1; sampled with d_in
- valid_in  input  1  d_in/sel_in valid
- ready_output  output  1  demux can accept on the selected channel
- y0_output  output  DATA_W  channel 0 head word
- y0_valid_output  output  1  channel 0 word valid
- y0_ready_in  input  1  channel 0 consumer ready
- y1_output  output  DATA_W  channel 1 head word
- y1_valid_output  output  1  channel 1 word valid
- y1_ready_in  input  1  channel 1 consumer ready
- xfer0_cnt_output  output  COUNT_W  channel 0 completed transfers
- xfer1_cnt_output  output  COUNT_W  channel 1 completed transfers

Behaviour:
- One clock (clk_in); reset is synchronous and active-high (rst_in), sampled on the rising edge.
- Reset: both buffers emptied (occupancy 0); y0_output = y1_output = 0; both valids = 0; both counters = 0. Reset asserted mid-transfer discards all buffered words; no handshake completes in a reset cycle.
- Per-channel buffer: 2-entry FIFO, occupancy 0/1/2. yN_output is the FIFO head; yN_valid_output = (occupancy != 0).
- ready_output is combinational: sel_in ? (occ1 != 2) : (occ0 != 2). It is independent of the yN_ready_in inputs (no ready pass-through). A full channel blocks input even if it pops in the same cycle.
- Input push: valid_in && ready_output at an edge writes d_in into the channel selected by sel_in; the unselected channel is untouched.
- Output pop: yN_valid_output && yN_ready_in at an edge removes the head; the next entry (if any) becomes head that same edge.
- Simultaneous push and pop on one channel: occupancy unchanged, order preserved. Push on one channel with pop on the other is independent.
- Latency: a word accepted at edge k appears on yN_output with yN_valid_output = 1 after edge k (1 cycle into an empty channel).
- Ordering: strict FIFO within a channel; no ordering guarantee across channels.
- Data is passed bit-exact (signed, no extension, truncation or arithmetic).
- Head value holds stable while valid and not popped. When a channel drains empty, yN_output holds its last value.
- sel_in and d_in are don't-care when valid_in = 0.

Optional Feature:
- Macro DEMUX_XFER_CNT_EN.
- Defined: xfer0_cnt_output / xfer1_cnt_output increment by 1 on each output-side handshake of their channel. They wrap from 2^COUNT_W-1 to 0 and reset to 0.
- Undefined: counter logic is not built; both count ports are driven constant 0. Ports remain present so the interface is identical.

Test Plan:
- Reset, then d_in=30, sel_in=0, valid_in=1 for one cycle, y0_ready_in=1 -> next cycle y0_output=30, y0_valid_output=1; y1_valid_output stays 0; with the macro defined, xfer0_cnt_output=1 after the pop.
- d_in=45, sel_in=1, one beat -> y1_output=45 one cycle later; channel 0 unaffected; a negative word (-128) passes bit-exact.
- y0_ready_in=0; push 10, 20 to channel 0 -> ready_output=0 while sel_in=0, =1 while sel_in=1. Raise y0_ready_in -> pops in order 10 then 20.
- Channel 0 holding 1 entry; same cycle push 7 and pop -> occupancy stays 1, next head = 7.
- Two entries in channel 1, assert rst_in for one cycle -> both valids 0, both outputs 0, counters 0, ready_output=1.
- Macro defined, COUNT_W=2: 5 pops on channel 0 -> counter sequence 1, 2, 3, 0, 1.
